// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the LEGv8 MEM stage.
package mem_stage_pkg;
  localparam int DW = 64;
  localparam int RW = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic Branch;
    logic MemRead;
    logic MemWrite;
    logic RegWrite;
    logic MemtoReg;
  } exmem_ctrl_t;

  function automatic logic is_mem_op(input exmem_ctrl_t c);
    return c.MemRead | c.MemWrite;
  endfunction
endpackage

// File: rtl/exmem_reg.sv
// Generic enabled pipeline register with synchronous active-high reset.
// Instantiated both as the EX/MEM and the MEM/WB register.
module exmem_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_stage.sv
// LEGv8 MEM stage: EX/MEM register, CBZ/B resolution, LDUR/STUR data-memory FSM.
// Optional MEM_ALIGN_CHECK_EN adds misalign_M and suppresses misaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int N  = DW,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic [N-1:0]  aluResult_E,
  input  logic [N-1:0]  writeData_E,
  input  logic [N-1:0]  PCBranch_E,
  input  logic          zero_E,
  input  logic          Branch_E,
  input  logic          MemRead_E,
  input  logic          MemWrite_E,
  input  logic          RegWrite_E,
  input  logic          MemtoReg_E,
  input  logic [RW-1:0] rd_E,
  output logic          stall_M,
  output logic          dm_req,
  output logic          dm_we,
  output logic [N-1:0]  dm_addr,
  output logic [N-1:0]  dm_wdata,
  input  logic          dm_ready,
  input  logic [N-1:0]  dm_rdata,
  output logic          PCSrc_M,
  output logic [N-1:0]  PCBranch_M,
  output logic          wb_valid,
  output logic [N-1:0]  aluResult_M,
  output logic [N-1:0]  readData_M,
  output logic [RW-1:0] rd_M,
  output logic          RegWrite_M,
  output logic          MemtoReg_M,
`ifdef MEM_ALIGN_CHECK_EN
  output logic          misalign_M,
`endif
  output mem_state_t    state_dbg
);
  localparam int CW = $bits(exmem_ctrl_t);
  localparam int XW = 3*N + 1 + CW + RW;
  localparam int WW = N + RW + 2;

  mem_state_t    state, state_d;
  exmem_ctrl_t   ctrl_E, ctrl_X;
  logic [N-1:0]  alu_X, wdata_X, pcb_X;
  logic          zero_X;
  logic [RW-1:0] rd_X;
  logic [XW-1:0] x_d, x_q;
  logic [WW-1:0] w_d, w_q;
  logic          accept, issue_E, mem_done, busy_wb, direct_wb, wb_en;
  logic          pend_q, acc_q;

  // Handshake: a request is presented while dm_req=1 with addr/wdata/we held
  // stable; it completes in the first cycle dm_ready=1 and the stage may
  // accept the next EX instruction in that same cycle.
  assign ctrl_E   = '{Branch: Branch_E, MemRead: MemRead_E, MemWrite: MemWrite_E,
                      RegWrite: RegWrite_E, MemtoReg: MemtoReg_E};
  assign stall_M  = (state == ACCESS) && !dm_ready;
  assign accept   = ex_valid && !stall_M;
  assign mem_done = (state == ACCESS) && dm_ready;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_E, misalign_X;
  assign misalign_E = is_mem_op(ctrl_E) && (aluResult_E[2:0] != 3'b000);
  assign misalign_X = is_mem_op(ctrl_X) && (alu_X[2:0] != 3'b000);
  assign issue_E    = is_mem_op(ctrl_E) && !misalign_E;
`else
  assign issue_E    = is_mem_op(ctrl_E);
`endif

  // A non-memory op accepted while the writeback slot is taken (memory
  // completion or an earlier pending op) waits one cycle in EX/MEM.
  assign busy_wb   = mem_done || pend_q;
  assign direct_wb = accept && !issue_E && !busy_wb;
  assign wb_en     = busy_wb || direct_wb;

  assign x_d = {aluResult_E, writeData_E, PCBranch_E, zero_E, ctrl_E, rd_E};
  exmem_reg #(.W(XW)) u_exmem (.clk(clk), .reset(reset), .en(accept), .d(x_d), .q(x_q));
  assign {alu_X, wdata_X, pcb_X, zero_X, ctrl_X, rd_X} = x_q;

  always_comb begin
    w_d = {aluResult_E, rd_E, RegWrite_E, MemtoReg_E};
    if (busy_wb) w_d = {alu_X, rd_X, ctrl_X.RegWrite, ctrl_X.MemtoReg};
`ifdef MEM_ALIGN_CHECK_EN
    if (busy_wb ? misalign_X : misalign_E) w_d[1] = 1'b0;
`endif
  end

  exmem_reg #(.W(WW)) u_memwb (.clk(clk), .reset(reset), .en(wb_en), .d(w_d), .q(w_q));
  assign {aluResult_M, rd_M, RegWrite_M, MemtoReg_M} = w_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      acc_q      <= 1'b0;
      wb_valid   <= 1'b0;
      readData_M <= '0;
    end else begin
      pend_q   <= accept && !issue_E && busy_wb;
      acc_q    <= accept;
      wb_valid <= wb_en;
      if (mem_done) begin
        if (!ctrl_X.MemWrite) readData_M <= dm_rdata;
        else if (ctrl_X.MemRead) readData_M <= '0;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) misalign_M <= 1'b0;
    else misalign_M <= wb_en && (busy_wb ? misalign_X : misalign_E);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end

  always_comb begin
    state_d = state;
    dm_req  = 1'b0;
    case (state)
      IDLE:   if (accept && issue_E) state_d = ACCESS;
      ACCESS: begin
        dm_req = 1'b1;
        if (dm_ready) state_d = (accept && issue_E) ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dm_we      = ctrl_X.MemWrite;
  assign dm_addr    = alu_X;
  assign dm_wdata   = wdata_X;
  assign PCSrc_M    = acc_q && ctrl_X.Branch && zero_X;
  assign PCBranch_M = pcb_X;
  assign state_dbg  = state;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// run against an in-order scoreboard and a simple memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_RW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] aluResult_E, writeData_E, PCBranch_E;
  logic        zero_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [4:0]  rd_E;
  logic        stall_M, dm_req, dm_we, dm_ready;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        PCSrc_M, wb_valid, RegWrite_M, MemtoReg_M;
  logic [63:0] PCBranch_M, aluResult_M, readData_M;
  logic [4:0]  rd_M;
  mem_state_t  state_dbg;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_M;
`endif

  int vec_count = 0;
  int miscompares = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .Branch_E(Branch_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .rd_E(rd_E),
    .stall_M(stall_M), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .wb_valid(wb_valid),
    .aluResult_M(aluResult_M), .readData_M(readData_M), .rd_M(rd_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_M(misalign_M),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; ex_valid = 1'b0; dm_ready = 1'b0; dm_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // driver tasks
  task automatic set_instr(input int kind, input logic [63:0] alu, input logic [63:0] wd,
                           input logic [63:0] pcb, input logic z, input logic [4:0] rd);
    ex_valid = 1'b1; aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
    zero_E = z; rd_E = rd;
    Branch_E   = (kind == K_BR);
    MemRead_E  = (kind == K_LD) || (kind == K_RW);
    MemWrite_E = (kind == K_ST) || (kind == K_RW);
    RegWrite_E = (kind == K_ALU) || (kind == K_LD);
    MemtoReg_E = (kind == K_LD);
  endtask

  task automatic test_reset();
    apply_reset();
    vec_count++;
    if ({wb_valid, dm_req, stall_M, PCSrc_M, RegWrite_M} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 00000", {wb_valid, dm_req, stall_M, PCSrc_M, RegWrite_M});
    end
    vec_count++;
    if ({aluResult_M, readData_M, dm_addr, PCBranch_M} !== 256'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", {aluResult_M, readData_M, dm_addr, PCBranch_M});
    end
  endtask

  task automatic test_alu();
    set_instr(K_ALU, 64'h10, 64'h0, 64'h0, 1'b0, 5'd3);
    @(negedge clk);
    ex_valid = 1'b0;
    vec_count++;
    if ({wb_valid, aluResult_M, rd_M, RegWrite_M, dm_req} !== {1'b1, 64'h10, 5'd3, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL alu_wb: got v=%b alu=%h rd=%0d rw=%b req=%b expected v=1 alu=10 rd=3 rw=1 req=0",
               wb_valid, aluResult_M, rd_M, RegWrite_M, dm_req);
    end
    @(negedge clk);
    vec_count++;
    if ({wb_valid, dm_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL alu_pulse: got v=%b req=%b expected 0 0", wb_valid, dm_req);
    end
  endtask

  task automatic test_load_wait();
    int req_cnt = 0, stall_cnt = 0;
    set_instr(K_LD, 64'h40, 64'h0, 64'h0, 1'b0, 5'd5);
    @(negedge clk);
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dm_ready = (i == 3); dm_rdata = 64'hDEADBEEF;
      #1;
      if (dm_req) req_cnt++;
      if (stall_M) stall_cnt++;
      vec_count++;
      if ({dm_addr, dm_we} !== {64'h40, 1'b0}) begin
        miscompares++;
        $display("FAIL ld_req: got addr=%h we=%b expected addr=40 we=0", dm_addr, dm_we);
      end
      @(negedge clk);
    end
    dm_ready = 1'b0;
    vec_count++;
    if ({req_cnt, stall_cnt} !== {32'd4, 32'd3}) begin
      miscompares++;
      $display("FAIL ld_counts: got req=%0d stall=%0d expected req=4 stall=3", req_cnt, stall_cnt);
    end
    vec_count++;
    if ({wb_valid, readData_M, rd_M, MemtoReg_M, dm_req} !== {1'b1, 64'hDEADBEEF, 5'd5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ld_wb: got v=%b data=%h rd=%0d m2r=%b req=%b expected v=1 data=deadbeef rd=5 m2r=1 req=0",
               wb_valid, readData_M, rd_M, MemtoReg_M, dm_req);
    end
    @(negedge clk);
    vec_count++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_pulse: got %b expected 0", wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    set_instr(K_ST, 64'h8, 64'h1234, 64'h0, 1'b0, 5'd1);
    #1;
    vec_count++;
    if (stall_M !== 1'b0) begin
      miscompares++; $display("FAIL st_stall0: got %b expected 0", stall_M);
    end
    @(negedge clk);
    dm_ready = 1'b1;
    set_instr(K_LD, 64'h18, 64'h0, 64'h0, 1'b0, 5'd7);
    #1;
    vec_count++;
    if ({dm_req, dm_we, dm_wdata, dm_addr, stall_M} !== {1'b1, 1'b1, 64'h1234, 64'h8, 1'b0}) begin
      miscompares++;
      $display("FAIL st_req: got req=%b we=%b wd=%h addr=%h stall=%b expected 1 1 1234 8 0",
               dm_req, dm_we, dm_wdata, dm_addr, stall_M);
    end
    @(negedge clk);
    ex_valid = 1'b0; dm_ready = 1'b0;
    vec_count++;
    if ({wb_valid, RegWrite_M, dm_req, dm_we, dm_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 64'h18}) begin
      miscompares++;
      $display("FAIL b2b_ld_req: got v=%b rw=%b req=%b we=%b addr=%h expected 1 0 1 0 18",
               wb_valid, RegWrite_M, dm_req, dm_we, dm_addr);
    end
    dm_ready = 1'b1; dm_rdata = 64'hCAFE;
    @(negedge clk);
    dm_ready = 1'b0;
    vec_count++;
    if ({wb_valid, readData_M, rd_M, dm_req} !== {1'b1, 64'hCAFE, 5'd7, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_ld_wb: got v=%b data=%h rd=%0d req=%b expected 1 cafe 7 0",
               wb_valid, readData_M, rd_M, dm_req);
    end
  endtask

  task automatic test_branch();
    set_instr(K_BR, 64'h0, 64'h0, 64'h200, 1'b1, 5'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    vec_count++;
    if ({PCSrc_M, PCBranch_M} !== {1'b1, 64'h200}) begin
      miscompares++;
      $display("FAIL br_taken: got src=%b tgt=%h expected 1 200", PCSrc_M, PCBranch_M);
    end
    @(negedge clk);
    vec_count++;
    if (PCSrc_M !== 1'b0) begin
      miscompares++; $display("FAIL br_pulse: got %b expected 0", PCSrc_M);
    end
    set_instr(K_BR, 64'h0, 64'h0, 64'h300, 1'b0, 5'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    vec_count++;
    if (PCSrc_M !== 1'b0) begin
      miscompares++; $display("FAIL br_not_taken: got %b expected 0", PCSrc_M);
    end
  endtask

  task automatic test_reset_in_access();
    set_instr(K_LD, 64'h80, 64'h0, 64'h0, 1'b0, 5'd9);
    @(negedge clk);
    ex_valid = 1'b0; dm_ready = 1'b0;
    vec_count++;
    if (dm_req !== 1'b1) begin
      miscompares++; $display("FAIL rst_acc_pre: got req=%b expected 1", dm_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec_count++;
    if ({dm_req, stall_M, wb_valid, rd_M} !== 8'h0 || {aluResult_M, readData_M, dm_addr} !== 192'h0) begin
      miscompares++;
      $display("FAIL rst_acc: got req=%b stall=%b v=%b rd=%0d alu=%h data=%h addr=%h expected all 0",
               dm_req, stall_M, wb_valid, rd_M, aluResult_M, readData_M, dm_addr);
    end
    @(negedge clk);
    vec_count++;
    if ({dm_req, wb_valid} !== 2'b00) begin
      miscompares++; $display("FAIL rst_acc_post: got req=%b v=%b expected 0 0", dm_req, wb_valid);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    set_instr(K_LD, 64'h44, 64'h0, 64'h0, 1'b0, 5'd4);
    @(negedge clk);
    ex_valid = 1'b0;
    vec_count++;
    if ({dm_req, misalign_M, wb_valid, RegWrite_M} !== 4'b0110) begin
      miscompares++;
      $display("FAIL misalign: got req=%b mis=%b v=%b rw=%b expected 0 1 1 0",
               dm_req, misalign_M, wb_valid, RegWrite_M);
    end
    @(negedge clk);
    vec_count++;
    if ({dm_req, misalign_M, wb_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL misalign_post: got req=%b mis=%b v=%b expected 0 0 0", dm_req, misalign_M, wb_valid);
    end
  endtask
`endif

  // randomized run: in-order scoreboard, memory model, branch/readData model
  task automatic test_random();
    logic [70:0] exp_q[$];
    logic [70:0] want, got;
    logic        out, o_we, o_both, stall_exp, pc_exp;
    logic [63:0] o_addr, o_wd, rd_model, pcb_exp, a, w, p;
    int          kind;
    apply_reset();
    out = 1'b0; o_we = 1'b0; o_both = 1'b0; o_addr = '0; o_wd = '0;
    rd_model = '0; pc_exp = 1'b0; pcb_exp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      vec_count++;
      if (readData_M !== rd_model) begin
        miscompares++; $display("FAIL rnd_rdata: got %h expected %h", readData_M, rd_model);
      end
      vec_count++;
      if (PCSrc_M !== pc_exp || (pc_exp && PCBranch_M !== pcb_exp)) begin
        miscompares++;
        $display("FAIL rnd_branch: got src=%b tgt=%h expected src=%b tgt=%h", PCSrc_M, PCBranch_M, pc_exp, pcb_exp);
      end
      if (wb_valid) begin
        vec_count++;
        got = {aluResult_M, rd_M, RegWrite_M, MemtoReg_M};
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rnd_wb_spurious: got %h expected no writeback", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            miscompares++; $display("FAIL rnd_wb: got %h expected %h", got, want);
          end
        end
      end
      if (cyc < 2800 && $urandom_range(0, 3) != 0) begin
        kind = $urandom_range(0, 4);
        a = {$urandom, $urandom} & ~64'h7;
        w = {$urandom, $urandom};
        p = {$urandom, $urandom};
        set_instr(kind, a, w, p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end else begin
        ex_valid = 1'b0;
      end
      dm_ready = out && ($urandom_range(0, 2) == 0);
      dm_rdata = {$urandom, $urandom};
      #1;
      stall_exp = out && !dm_ready;
      vec_count++;
      if ({stall_M, dm_req} !== {stall_exp, out}) begin
        miscompares++;
        $display("FAIL rnd_hs: got stall=%b req=%b expected stall=%b req=%b", stall_M, dm_req, stall_exp, out);
      end
      if (out) begin
        vec_count++;
        if ({dm_addr, dm_we} !== {o_addr, o_we} || (o_we && dm_wdata !== o_wd)) begin
          miscompares++;
          $display("FAIL rnd_req: got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h",
                   dm_addr, dm_we, dm_wdata, o_addr, o_we, o_wd);
        end
      end
      if (out && dm_ready) begin
        if (!o_we) rd_model = dm_rdata;
        else if (o_both) rd_model = '0;
        out = 1'b0;
      end
      pc_exp = 1'b0;
      if (ex_valid && !stall_exp) begin
        exp_q.push_back({aluResult_E, rd_E, RegWrite_E, MemtoReg_E});
        pc_exp = Branch_E && zero_E;
        pcb_exp = PCBranch_E;
        if (MemRead_E || MemWrite_E) begin
          out = 1'b1; o_addr = aluResult_E; o_wd = writeData_E;
          o_we = MemWrite_E; o_both = MemRead_E && MemWrite_E;
        end
      end
    end
    ex_valid = 1'b0; dm_ready = 1'b0;
    vec_count++;
    if (exp_q.size() != 0 || out) begin
      miscompares++;
      $display("FAIL rnd_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; dm_ready = 1'b0; dm_rdata = '0;
    aluResult_E = '0; writeData_E = '0; PCBranch_E = '0; zero_E = 1'b0; rd_E = '0;
    Branch_E = 1'b0; MemRead_E = 1'b0; MemWrite_E = 1'b0; RegWrite_E = 1'b0; MemtoReg_E = 1'b0;
    test_reset();
    test_alu();
    test_load_wait();
    test_back_to_back();
    test_branch();
    test_reset_in_access();
`ifdef MEM_ALIGN_CHECK_EN
    apply_reset();
    test_misalign();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 64-bit LEGv8 pipeline; sits directly downstream of the execute stage.
- Registers execute results (EX/MEM register), resolves CBZ/B branches, and runs data-memory LDUR/STUR through a valid/ready handshake.
- Stalls upstream while a memory access is outstanding; delivers results to writeback.

Parameters:
N, 64, datapath/address width
RW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
ex_valid  in  1  execute stage presents a valid instruction
aluResult_E  in  N  ALU result / memory address
writeData_E  in  N  store data
PCBranch_E  in  N  branch target
zero_E  in  1  ALU zero flag
Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E  in  1 each  control bits
rd_E  in  RW  destination register
stall_M  out  1  upstream must hold; EX inputs not accepted this cycle
dm_req  out  1  data-memory request valid
dm_we  out  1  1 = write (STUR), 0 = read (LDUR)
dm_addr  out  N  memory address
dm_wdata  out  N  store data
dm_ready  in  1  memory completes the current request this cycle
dm_rdata  in  N  load data, valid when dm_ready=1 and dm_we=0
PCSrc_M  out  1  take branch, one-cycle pulse
PCBranch_M  out  N  registered branch target
wb_valid  out  1  writeback bundle valid, one-cycle pulse per instruction
aluResult_M, readData_M  out  N each  to writeback mux
rd_M  out  RW; RegWrite_M, MemtoReg_M  out  1 each

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Reset: all outputs 0, state IDLE.
- accept = ex_valid & ~stall_M. On accept, capture all *_E inputs into the EX/MEM register.
- FSM states: IDLE, ACCESS.
- IDLE, accept of a non-memory op: stay IDLE. Next cycle: wb_valid=1 with aluResult_M, rd_M, RegWrite_M, MemtoReg_M. Latency 1.
- IDLE, accept with MemRead or MemWrite: go to ACCESS. From the next cycle, dm_req=1 with dm_addr, dm_wdata, and dm_we held stable until dm_ready.
- ACCESS, dm_ready=0: stay in ACCESS; stall_M=1 (combinational: state==ACCESS & ~dm_ready).
- ACCESS, dm_ready=1: capture dm_rdata into readData_M (reads only) and signal wb_valid next cycle. stall_M=0 in this same cycle, so a new EX instruction may be accepted and the FSM goes straight to ACCESS again if that instruction is a memory op (back-to-back). Otherwise go to IDLE.
- Load latency = 1 + wait cycles + 1. Minimum: accept at T, dm_ready at T+1, wb_valid at T+2.
- Stores: wb_valid still pulses; RegWrite_M is passed through as captured (0 for STUR).
- MemRead & MemWrite both set: treated as a write; readData_M=0.
- Branch: PCSrc_M = captured Branch & captured zero, asserted in the cycle after accept together with PCBranch_M. It is not delayed by the memory access. Flushing of younger stages belongs to the hazard unit.
- readData_M holds its last value when no load completes; wb_valid=0 in every cycle without a completion.
- Reset during ACCESS: dm_req drops the next cycle, the pending access is abandoned, and no wb_valid is issued. The memory must tolerate the abandoned request.
- ex_valid=0: no capture and no wb_valid. Registered values hold.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: adds output misalign_M (1 bit). On accept of a memory op with aluResult_E[2:0] != 0:
  - no dm_req is issued and the FSM stays IDLE;
  - the next cycle, misalign_M=1 and wb_valid=1 with RegWrite_M forced to 0.
  - misalign_M resets to 0.
- Undefined: no misalign_M port; the address goes to memory unmodified.

Decomposition:
- Shared package holds:
  - mem_state_t enum {IDLE, ACCESS};
  - struct exmem_ctrl_t {Branch, MemRead, MemWrite, RegWrite, MemtoReg};
  - constants DW=64 and RW=5.
- One natural sub-module: exmem_reg. It is the parameterised EX/MEM pipeline register with an enable (accept), and is reused for the MEM/WB register. The FSM and handshake stay in mem_stage.

Test Plan:
- ADD-class op, aluResult_E=0x10, rd_E=3, RegWrite=1 → next cycle wb_valid=1, aluResult_M=0x10, rd_M=3; dm_req never asserted.
- LDUR addr 0x40, dm_ready after 3 wait cycles with rdata 0xDEADBEEF → dm_req high 4 cycles, stall_M high 3 cycles, readData_M=0xDEADBEEF, wb_valid one cycle later.
- STUR addr 0x8, data 0x1234, dm_ready immediate → one cycle with dm_req=1, dm_we=1, dm_wdata=0x1234, stall_M never high; a following LDUR is accepted back-to-back in the dm_ready cycle.
- CBZ with Branch=1, zero_E=1, PCBranch_E=0x200 → PCSrc_M=1 for exactly one cycle with PCBranch_M=0x200; with zero_E=0, PCSrc_M stays 0.
- reset asserted during ACCESS with dm_ready=0 → next cycle dm_req=0, stall_M=0, all outputs 0, no wb_valid.
- MEM_ALIGN_CHECK_EN: LDUR addr 0x44 → no dm_req, misalign_M=1, wb_valid=1, RegWrite_M=0.
